// File: rtl/inv_mix_columns_seq.sv
// Iterative AES InvMixColumns engine: takes one 128-bit state, transforms
// COLS_PER_CYCLE columns per clock, and holds the result until it is taken downstream.
module inv_mix_columns_seq #(
    parameter int unsigned COLS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] state_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] state_out
);

    localparam int unsigned STATE_W = 128;
    localparam int unsigned COL_W   = 32;

    if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cols
        $error("inv_mix_columns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } fsm_e;

    fsm_e               state_q, state_d;
    logic [1:0]         col_cnt_q, col_cnt_d;
    logic [STATE_W-1:0] work_q, work_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;
    logic               last_step;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Returns {0E*b, 0B*b, 0D*b, 09*b} built from the x2/x4/x8 multiples.
    function automatic logic [31:0] inv_mults(input logic [7:0] b);
        logic [7:0] x2, x4, x8;
        x2 = xtime(b);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return {x8 ^ x4 ^ x2, x8 ^ x2 ^ b, x8 ^ x4 ^ b, x8 ^ b};
    endfunction

    function automatic logic [COL_W-1:0] inv_mix_col(input logic [COL_W-1:0] col);
        logic [31:0] m0, m1, m2, m3;
        m0 = inv_mults(col[31:24]);
        m1 = inv_mults(col[23:16]);
        m2 = inv_mults(col[15:8]);
        m3 = inv_mults(col[7:0]);
        // Fields: [31:24]=0E, [23:16]=0B, [15:8]=0D, [7:0]=09
        return {m0[31:24] ^ m1[23:16] ^ m2[15:8]  ^ m3[7:0],
                m1[31:24] ^ m2[23:16] ^ m3[15:8]  ^ m0[7:0],
                m2[31:24] ^ m3[23:16] ^ m0[15:8]  ^ m1[7:0],
                m3[31:24] ^ m0[23:16] ^ m1[15:8]  ^ m2[7:0]};
    endfunction

    // MSB position of column (cnt + i) within the 128-bit state.
    function automatic logic [6:0] col_msb(input logic [1:0] cnt, input int unsigned i);
        logic [1:0] c;
        c = 2'(32'(cnt) + i);
        return 7'd127 - {c, 5'd0};
    endfunction

    assign last_step = (({1'b0, col_cnt_q} + 3'(COLS_PER_CYCLE)) == 3'd4);

    always_comb begin
        state_d     = state_q;
        col_cnt_d   = col_cnt_q;
        work_d      = work_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    work_d     = state_in;
                    col_cnt_d  = 2'd0;
                    state_d    = BUSY;
                    in_ready_d = 1'b0;
                end
            end
            BUSY: begin
                for (int unsigned i = 0; i < COLS_PER_CYCLE; i++) begin
                    work_d[col_msb(col_cnt_q, i) -: COL_W] =
                        inv_mix_col(work_q[col_msb(col_cnt_q, i) -: COL_W]);
                end
                col_cnt_d = col_cnt_q + 2'(COLS_PER_CYCLE);
                if (last_step) begin
                    state_d     = DONE;
                    out_valid_d = 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                end
            end
            default: begin
                state_d     = IDLE;
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            col_cnt_q   <= 2'd0;
            work_q      <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            col_cnt_q   <= col_cnt_d;
            work_q      <= work_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign state_out = work_q;

endmodule

// File: tb/tb_inv_mix_columns_seq.sv
// Directed bench for inv_mix_columns_seq: one instance per legal COLS_PER_CYCLE
// (index d -> 1 << d columns per clock), checked against hand vectors and a GF model.
module tb_inv_mix_columns_seq;

    localparam logic [127:0] KNOWN_IN  = 128'h4d7ebdf8_8e4da1bc_01010101_d5d5d7d6;
    localparam logic [127:0] KNOWN_OUT = 128'h2d26314c_db135345_01010101_d4d4d4d5;

    logic         clk;
    logic         rst;
    logic         in_valid  [3];
    logic         in_ready  [3];
    logic [127:0] state_in  [3];
    logic         out_valid [3];
    logic         out_ready [3];
    logic [127:0] state_out [3];

    int n_cmp;
    int n_err;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        inv_mix_columns_seq #(.COLS_PER_CYCLE(1 << g)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (in_valid[g]),
            .in_ready  (in_ready[g]),
            .state_in  (state_in[g]),
            .out_valid (out_valid[g]),
            .out_ready (out_ready[g]),
            .state_out (state_out[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Shift-and-add field multiply, reduction by 0x11B.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = x[7] ? (8'({x, 1'b0}) ^ 8'h1b) : 8'({x, 1'b0});
        end
        return p;
    endfunction

    function automatic logic [127:0] model(input logic [127:0] s);
        logic [127:0] res;
        logic [7:0]   a [4];
        res = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) a[r] = s[127 - 8*(4*c + r) -: 8];
            for (int r = 0; r < 4; r++)
                res[127 - 8*(4*c + r) -: 8] = gmul(a[r], 8'h0e) ^ gmul(a[(r+1)%4], 8'h0b)
                                            ^ gmul(a[(r+2)%4], 8'h0d) ^ gmul(a[(r+3)%4], 8'h09);
        end
        return res;
    endfunction

    // Present one state; returns at the falling edge after the accept edge.
    task automatic start(input int d, input logic [127:0] din);
        @(negedge clk);
        check("accept_ready", 128'(in_ready[d]), 128'd1);
        state_in[d] = din;
        in_valid[d] = 1'b1;
        @(negedge clk);
        in_valid[d] = 1'b0;
    endtask

    task automatic wait_valid(input int d, output int lat);
        lat = 0;
        while (!out_valid[d] && lat < 20) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic transact(input int d, input logic [127:0] din, input logic [127:0] exp,
                            input string tag);
        int lat;
        out_ready[d] = 1'b1;
        start(d, din);
        wait_valid(d, lat);
        check({tag, "_lat"}, 128'(lat), 128'(4 >> d));
        check({tag, "_data"}, state_out[d], exp);
        @(negedge clk);
        check({tag, "_release"}, 128'({out_valid[d], in_ready[d]}), 128'(2'b01));
    endtask

    task automatic b2b(input int d);
        logic [127:0] vin [16];
        int n_in, n_out, cyc, last;
        bit acc;
        for (int i = 0; i < 16; i++) vin[i] = {$urandom, $urandom, $urandom, $urandom};
        @(negedge clk);
        out_ready[d] = 1'b1;
        state_in[d]  = vin[0];
        in_valid[d]  = 1'b1;
        n_in = 0; n_out = 0; cyc = 0; last = 0;
        while (n_out < 16 && cyc < 400) begin
            if (out_valid[d]) begin
                check("b2b_data", state_out[d], model(vin[n_out]));
                if (n_out > 0) check("b2b_spacing", 128'(cyc - last), 128'((4 >> d) + 2));
                last = cyc;
                n_out++;
            end
            acc = in_valid[d] && in_ready[d];
            @(posedge clk);
            #1;
            if (acc) begin
                n_in++;
                if (n_in < 16) state_in[d] = vin[n_in];
                else in_valid[d] = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        in_valid[d] = 1'b0;
        check("b2b_count", 128'(n_out), 128'd16);
    endtask

    initial begin
        logic [127:0] a_st, b_st, din;
        logic [7:0]   v;
        int lat;
        n_cmp = 0;
        n_err = 0;
        rst   = 1'b1;
        for (int d = 0; d < 3; d++) begin
            in_valid[d]  = 1'b0;
            out_ready[d] = 1'b1;
            state_in[d]  = '0;
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;

        for (int d = 0; d < 3; d++) begin
            check("rst_in_ready", 128'(in_ready[d]), 128'd1);
            check("rst_out_valid", 128'(out_valid[d]), 128'd0);
            check("rst_state_out", state_out[d], 128'd0);
        end

        for (int d = 0; d < 3; d++) transact(d, KNOWN_IN, KNOWN_OUT, "known");
        for (int d = 0; d < 3; d++)
            transact(d, {8'hae, 120'h0}, {32'hcea927ee, 96'h0}, "corner_ae");

        for (int d = 0; d < 3; d++) begin
            for (int i = 0; i < 256; i++) begin
                v   = 8'(i);
                din = {v, 24'h0, 64'h0, 16'h0, ~v, 8'h0};
                transact(d, din, model(din), "sweep");
            end
        end

        // Backpressure in DONE
        a_st = 128'h00112233_44556677_8899aabb_ccddeeff;
        out_ready[0] = 1'b0;
        start(0, a_st);
        wait_valid(0, lat);
        check("bp_lat", 128'(lat), 128'd4);
        repeat (10) begin
            @(negedge clk);
            check("bp_valid", 128'(out_valid[0]), 128'd1);
            check("bp_ready", 128'(in_ready[0]), 128'd0);
            check("bp_data", state_out[0], model(a_st));
        end
        out_ready[0] = 1'b1;
        @(negedge clk);
        check("bp_release", 128'({out_valid[0], in_ready[0]}), 128'(2'b01));

        // New input offered during BUSY and DONE must be ignored
        b_st = 128'hdeadbeef_01234567_89abcdef_fedcba98;
        out_ready[0] = 1'b0;
        start(0, a_st);
        state_in[0] = b_st;
        in_valid[0] = 1'b1;
        wait_valid(0, lat);
        check("ign_lat", 128'(lat), 128'd4);
        repeat (2) begin
            @(negedge clk);
            check("ign_ready", 128'(in_ready[0]), 128'd0);
            check("ign_data", state_out[0], model(a_st));
        end
        out_ready[0] = 1'b1;
        @(negedge clk);
        check("ign_idle_ready", 128'(in_ready[0]), 128'd1);
        @(negedge clk);
        in_valid[0] = 1'b0;
        wait_valid(0, lat);
        check("ign_second_lat", 128'(lat), 128'd4);
        check("ign_second_data", state_out[0], model(b_st));
        @(negedge clk);
        check("ign_second_release", 128'(in_ready[0]), 128'd1);

        // Reset while BUSY with col_cnt = 2
        start(0, a_st);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_out_valid", 128'(out_valid[0]), 128'd0);
        check("mid_rst_state_out", state_out[0], 128'd0);
        check("mid_rst_in_ready", 128'(in_ready[0]), 128'd1);
        transact(0, KNOWN_IN, KNOWN_OUT, "after_rst");

        for (int d = 0; d < 3; d++) b2b(d);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
